video_timing_rx: RTL and testbench
==================================

# video_timing_rx

Receive-side counterpart of the test-pattern timing generator. It consumes a parallel video stream (active-low VS/HS, DE, 8-bit grey pixel) and recovers the pixel coordinates. It measures the frame geometry, declares lock once the geometry is stable, and decimates a 2x-upscaled image window back to native resolution as a frame-buffer write stream. It sits between a video source (loop-back of the generator or an external decoder) and the image RAM that the loader reads.

## Interface
Parameters:
- WIN_W, 225, native window width in written pixels
- WIN_H, 225, native window height in written lines
- SCALE_LOG2, 1, decimation factor 2^SCALE_LOG2 in both axes (window spans 450x450 input pixels)
- AW, 16, write address width (must satisfy WIN_W*WIN_H <= 2^AW)

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_vs  in  1  vertical sync, active low
- i_hs  in  1  horizontal sync, active low
- i_de  in  1  data enable, active high
- i_data  in  8  pixel value
- o_sof  out  1  one-cycle pulse with the first pixel of each frame
- o_pix_valid  out  1  active pixel present on o_pix_data/o_x/o_y
- o_pix_data  out  8  pixel value
- o_x, o_y  out  12 each  coordinates of the current active pixel
- o_wr_en  out  1  frame-buffer write strobe
- o_wr_addr  out  AW  write address
- o_wr_data  out  8  write data
- o_h_total, o_h_active, o_v_total, o_v_active  out  12 each  last measured geometry
- o_locked  out  1  geometry stable

## Operation
- Input stage: i_vs/i_hs/i_de/i_data registered once. Edges are detected on the registered copies: VS fall (frame sync), HS fall (line sync), DE rise and DE fall.
- FSM states: WAIT_VS (reset), ARMED, ACTIVE.
  - WAIT_VS -> ARMED on VS fall. No pixel output in WAIT_VS; DE is ignored.
  - ARMED -> ACTIVE on DE rise: o_sof pulses, x=0, y=0.
  - ACTIVE -> ARMED on VS fall: frame is finalized (measurements latched, lock evaluated).
- In ACTIVE:
  - DE rise resets x to 0. x increments per DE-high cycle.
  - DE fall increments y and latches the line's DE-high length as the candidate h_active.
- h_total: clocks between consecutive HS falls, latched at each HS fall. Counted in all states.
- v_total: HS falls between consecutive VS falls. v_active: DE falls in the same interval. Both are latched at VS fall.
- All measurement counters saturate at 4095.
- Lock:
  - At each VS fall, the new {h_total, h_active, v_total, v_active} is compared with the previous frame's set.
  - Equal and all nonzero -> o_locked=1. Any difference -> o_locked=0 on that same update.
  - The previous set is then replaced by the new one.
- Decimation:
  - A pixel is written iff x < WIN_W<<SCALE_LOG2, y < WIN_H<<SCALE_LOG2, and the low SCALE_LOG2 bits of both x and y are zero.
  - o_wr_addr = (y>>SCALE_LOG2)*WIN_W + (x>>SCALE_LOG2). Compute it with a running line-base register (add WIN_W on each qualifying line end), not a multiplier.
  - o_wr_data = pixel value.
- Writes happen regardless of o_locked; downstream gates on o_locked if required.

## Timing
- Reset values:
  - all outputs 0, o_locked=0
  - FSM=WAIT_VS
  - measurement and previous-set registers 0
  - line base 0
- Latency: input sample at edge N -> o_pix_valid/o_pix_data/o_x/o_y and o_wr_* at edge N+2.
- o_sof is coincident with the first o_pix_valid of the frame.
- Measurement outputs and o_locked update 2 cycles after the VS-fall sample and hold until the next VS fall.
- Simultaneous VS fall and DE rise in ARMED: VS takes precedence; the state stays ARMED and no sof is issued.
- Simultaneous HS fall and DE fall: both are processed in the same cycle.
- VS fall mid-line in ACTIVE: the partial line is abandoned, y is not incremented further, and the frame is finalized.
- Asynchronous reset mid-frame: outputs clear immediately; resynchronization starts at the next VS fall.
- No backpressure: a write is issued every qualifying cycle.

## Test plan
- 640x480 stream (H_total 800, HS low at 656..751; V_total 525, VS low on lines 490..491), 3 frames:
  - after frame 2: o_h_total=800, o_h_active=640, o_v_total=525, o_v_active=480
  - o_locked rises after frame 3's VS fall
- Same stream, count writes: exactly 50625 writes per frame.
  - first write at addr 0 for input (0,0)
  - addr 224 for input (448,0), addr 225 for (0,2)
  - last write at addr 50624 for (448,448)
  - no write for x=450 or y=450
- DE pulses before any VS fall after reset: o_pix_valid and o_wr_en stay 0 and no o_sof; the first o_sof comes with the first DE rise after the first VS fall.
- Locked stream, then one frame with 479 active lines: o_locked drops at that frame's VS fall and reasserts at the second consecutive matching frame.
- rst_n pulsed low for 3 cycles at line 200: all outputs are 0 during reset; the next frame reports the correct geometry and o_locked reasserts after two further frames.
- Pixel value ramp i_data = x[7:0]: o_wr_data at addr k equals ((2k mod 450) mod 256) within the first line, and arrives exactly 2 cycles after input.

Source files
------------

// File: rtl/video_timing_rx.sv
// rtl/video_timing_rx.sv - video stream receiver: coordinate recovery, geometry lock, 2^n window decimation
// Pipeline: input registers -> coordinate/state stage -> registered outputs.
module video_timing_rx #(
  parameter int WIN_W      = 225,
  parameter int WIN_H      = 225,
  parameter int SCALE_LOG2 = 1,
  parameter int AW         = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vs,
  input  logic          i_hs,
  input  logic          i_de,
  input  logic [7:0]    i_data,
  output logic          o_sof,
  output logic          o_pix_valid,
  output logic [7:0]    o_pix_data,
  output logic [11:0]   o_x,
  output logic [11:0]   o_y,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [7:0]    o_wr_data,
  output logic [11:0]   o_h_total,
  output logic [11:0]   o_h_active,
  output logic [11:0]   o_v_total,
  output logic [11:0]   o_v_active,
  output logic          o_locked
);

  localparam logic [11:0] LIM_X = 12'(WIN_W << SCALE_LOG2);
  localparam logic [11:0] LIM_Y = 12'(WIN_H << SCALE_LOG2);
  localparam logic [11:0] SMASK = 12'((1 << SCALE_LOG2) - 1);

  typedef enum logic [1:0] {WAIT_VS, ARMED, ACTIVE} state_t;

  function automatic logic [11:0] f_sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  logic          r_vs, r_hs, r_de, r_vs_d, r_hs_d, r_de_d;
  logic [7:0]    r_data;
  state_t        r_state;
  logic          r_b_valid, r_b_sof;
  logic [11:0]   r_b_x, r_b_y;
  logic [7:0]    r_b_data;
  logic [AW-1:0] r_line_base;
  logic [11:0]   r_h_cnt, r_h_line, r_de_len, r_ha_line, r_v_cnt, r_va_cnt;
  logic [11:0]   r_m_ht, r_m_ha, r_m_vt, r_m_va;
  logic          r_lock;

  logic w_vs_fall, w_hs_fall, w_de_rise, w_de_fall, w_match, w_y_qual, w_qual;

  assign w_vs_fall = r_vs_d & ~r_vs;
  assign w_hs_fall = r_hs_d & ~r_hs;
  assign w_de_rise = r_de & ~r_de_d;
  assign w_de_fall = ~r_de & r_de_d;
  assign w_y_qual  = (r_b_y < LIM_Y) && ((r_b_y & SMASK) == 12'd0);
  assign w_qual    = r_b_valid && w_y_qual && (r_b_x < LIM_X) && ((r_b_x & SMASK) == 12'd0);
  assign w_match   = (r_h_line == r_m_ht) && (r_ha_line == r_m_ha) && (r_v_cnt == r_m_vt) &&
                     (r_va_cnt == r_m_va) && (r_h_line != 12'd0) && (r_ha_line != 12'd0) &&
                     (r_v_cnt != 12'd0) && (r_va_cnt != 12'd0);

  // Sync registers clear to 0 so no spurious falling edge follows reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_vs, r_hs, r_de, r_vs_d, r_hs_d, r_de_d} <= 6'd0;
      r_data <= 8'd0;
    end else begin
      {r_vs, r_hs, r_de} <= {i_vs, i_hs, i_de};
      {r_vs_d, r_hs_d, r_de_d} <= {r_vs, r_hs, r_de};
      r_data <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_VS;
      r_b_valid   <= 1'b0;
      r_b_sof     <= 1'b0;
      r_b_x       <= 12'd0;
      r_b_y       <= 12'd0;
      r_b_data    <= 8'd0;
      r_line_base <= '0;
    end else begin
      r_b_sof  <= 1'b0;
      r_b_data <= r_data;
      case (r_state)
        WAIT_VS: begin
          r_b_valid <= 1'b0;
          if (w_vs_fall) r_state <= ARMED;
        end
        ARMED: begin
          r_b_valid <= 1'b0;
          if (!w_vs_fall && w_de_rise) begin
            r_state     <= ACTIVE;
            r_b_valid   <= 1'b1;
            r_b_sof     <= 1'b1;
            r_b_x       <= 12'd0;
            r_b_y       <= 12'd0;
            r_line_base <= '0;
          end
        end
        ACTIVE: begin
          if (w_vs_fall) begin
            r_state   <= ARMED;
            r_b_valid <= 1'b0;
          end else begin
            r_b_valid <= r_de;
            if (w_de_rise) r_b_x <= 12'd0;
            else if (r_de) r_b_x <= f_sat_inc(r_b_x);
            // The line that just ended decides whether the write base advances.
            if (w_de_fall) begin
              r_b_y <= f_sat_inc(r_b_y);
              if (w_y_qual) r_line_base <= r_line_base + AW'(WIN_W);
            end
          end
        end
        default: r_state <= WAIT_VS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= 12'd0; r_h_line <= 12'd0; r_de_len <= 12'd0; r_ha_line <= 12'd0;
      r_v_cnt <= 12'd0; r_va_cnt <= 12'd0;
      r_m_ht  <= 12'd0; r_m_ha <= 12'd0; r_m_vt <= 12'd0; r_m_va <= 12'd0;
      r_lock  <= 1'b0;
    end else begin
      if (w_hs_fall) begin
        r_h_line <= r_h_cnt;
        r_h_cnt  <= 12'd1;
      end else begin
        r_h_cnt <= f_sat_inc(r_h_cnt);
      end
      if (w_de_rise) r_de_len <= 12'd1;
      else if (r_de) r_de_len <= f_sat_inc(r_de_len);
      if (w_vs_fall) begin
        r_v_cnt  <= {11'd0, w_hs_fall};
        r_va_cnt <= 12'd0;
      end else begin
        if (w_hs_fall) r_v_cnt <= f_sat_inc(r_v_cnt);
        if (r_state == ACTIVE && w_de_fall) begin
          r_ha_line <= r_de_len;
          r_va_cnt  <= f_sat_inc(r_va_cnt);
        end
      end
      // The latched set doubles as the previous-frame reference for the next comparison.
      if (w_vs_fall && r_state != WAIT_VS) begin
        r_m_ht <= r_h_line;
        r_m_ha <= r_ha_line;
        r_m_vt <= r_v_cnt;
        r_m_va <= r_va_cnt;
        r_lock <= w_match;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sof <= 1'b0; o_pix_valid <= 1'b0; o_pix_data <= 8'd0; o_x <= 12'd0; o_y <= 12'd0;
      o_wr_en <= 1'b0; o_wr_addr <= '0; o_wr_data <= 8'd0;
      o_h_total <= 12'd0; o_h_active <= 12'd0; o_v_total <= 12'd0; o_v_active <= 12'd0;
      o_locked <= 1'b0;
    end else begin
      o_sof       <= r_b_sof;
      o_pix_valid <= r_b_valid;
      o_pix_data  <= r_b_data;
      o_x         <= r_b_x;
      o_y         <= r_b_y;
      o_wr_en     <= w_qual;
      o_wr_addr   <= r_line_base + AW'(r_b_x >> SCALE_LOG2);
      o_wr_data   <= r_b_data;
      o_h_total   <= r_m_ht;
      o_h_active  <= r_m_ha;
      o_v_total   <= r_m_vt;
      o_v_active  <= r_m_va;
      o_locked    <= r_lock;
    end
  end

endmodule

// File: tb/tb_video_timing_rx.sv
// tb/tb_video_timing_rx.sv - randomized scoreboard bench for video_timing_rx
module tb_video_timing_rx;
  localparam int WIN_W = 8;
  localparam int WIN_H = 6;
  localparam int SCALE_LOG2 = 1;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_vs, i_hs, i_de;
  logic [7:0]    i_data;
  logic          o_sof, o_pix_valid, o_wr_en, o_locked;
  logic [7:0]    o_pix_data, o_wr_data;
  logic [11:0]   o_x, o_y, o_h_total, o_h_active, o_v_total, o_v_active;
  logic [AW-1:0] o_wr_addr;

  video_timing_rx #(.WIN_W(WIN_W), .WIN_H(WIN_H), .SCALE_LOG2(SCALE_LOG2), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de), .i_data(i_data),
    .o_sof(o_sof), .o_pix_valid(o_pix_valid), .o_pix_data(o_pix_data), .o_x(o_x), .o_y(o_y),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_h_total(o_h_total), .o_h_active(o_h_active), .o_v_total(o_v_total), .o_v_active(o_v_active),
    .o_locked(o_locked)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int x; int y; int d; int sof; int cyc; } pix_t;
  typedef struct { int addr; int d; int cyc; } wr_t;

  pix_t q_pix[$];
  wr_t  q_wr[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int v_act_n, v_tot, vs_s;
  int m_sync, m_track, m_lock, m_ht, m_ha, m_vt, m_va;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("reset_outputs", int'(|{o_sof, o_pix_valid, o_pix_data, o_x, o_y, o_wr_en, o_wr_addr, o_wr_data,
        o_h_total, o_h_active, o_v_total, o_v_active, o_locked}), 0);
  endtask

  task automatic check_geom();
    chk("h_total", int'(o_h_total), m_ht);
    chk("h_active", int'(o_h_active), m_ha);
    chk("v_total", int'(o_v_total), m_vt);
    chk("v_active", int'(o_v_active), m_va);
    chk("locked", int'(o_locked), m_lock);
  endtask

  task automatic finalize(input int ht, input int ha, input int vt, input int va);
    m_lock = (ht == m_ht && ha == m_ha && vt == m_vt && va == m_va &&
              ht != 0 && ha != 0 && vt != 0 && va != 0) ? 1 : 0;
    m_ht = ht; m_ha = ha; m_vt = vt; m_va = va;
  endtask

  task automatic drive_cycle(input logic vs, input logic hs, input logic de, input logic [7:0] d);
    @(posedge clk);
    #1;
    i_vs = vs; i_hs = hs; i_de = de; i_data = d;
  endtask

  // Frame: active lines first, VS low for two whole lines starting at vs_s, HS low 4 clocks after active.
  task automatic send_frame(input int ht, input int ha, input int va, input int rst_line);
    int hs_s;
    logic vs, hs, de;
    logic [7:0] d;
    pix_t p;
    wr_t w;
    hs_s = ha + 3;
    m_track = m_sync;
    for (int l = 0; l < v_tot; l++) begin
      for (int c = 0; c < ht; c++) begin
        vs = (l >= vs_s && l < vs_s + 2) ? 1'b0 : 1'b1;
        hs = (c >= hs_s && c < hs_s + 4) ? 1'b0 : 1'b1;
        de = (l < va && c < ha) ? 1'b1 : 1'b0;
        d  = 8'($urandom);
        drive_cycle(vs, hs, de, d);
        if (l == rst_line && c == 5) begin
          rst_n = 1'b0;
          q_pix.delete();
          q_wr.delete();
          m_sync = 0; m_track = 0; m_lock = 0;
          m_ht = 0; m_ha = 0; m_vt = 0; m_va = 0;
          #1;
          chk_reset_outputs();
        end else if (l == rst_line && (c == 6 || c == 7)) begin
          #1;
          chk_reset_outputs();
        end else if (l == rst_line && c == 8) begin
          rst_n = 1'b1;
        end
        if (de && m_track != 0) begin
          p.x = c; p.y = l; p.d = int'(d); p.sof = (c == 0 && l == 0) ? 1 : 0; p.cyc = cyc + 3;
          q_pix.push_back(p);
          if (c < (WIN_W << SCALE_LOG2) && l < (WIN_H << SCALE_LOG2) &&
              (c % (1 << SCALE_LOG2)) == 0 && (l % (1 << SCALE_LOG2)) == 0) begin
            w.addr = (l >> SCALE_LOG2) * WIN_W + (c >> SCALE_LOG2);
            w.d = int'(d);
            w.cyc = cyc + 3;
            q_wr.push_back(w);
          end
        end
        if (l == vs_s && c == 0) begin
          if (m_sync != 0) finalize(ht, ha, v_tot, va);
          m_sync = 1;
        end
        if (l == vs_s && c == 6) check_geom();
      end
    end
  endtask

  initial begin
    pix_t p;
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_pix_valid) begin
          checks++;
          if (q_pix.size() == 0) begin
            errors++;
            $display("FAIL pix_unexpected: got x=%0d y=%0d, required no pixel", o_x, o_y);
          end else begin
            p = q_pix.pop_front();
            if (int'(o_x) != p.x || int'(o_y) != p.y || int'(o_pix_data) != p.d ||
                int'(o_sof) != p.sof || cyc != p.cyc) begin
              errors++;
              $display("FAIL pix: got x=%0d y=%0d d=%0d sof=%0d cyc=%0d, required x=%0d y=%0d d=%0d sof=%0d cyc=%0d",
                       o_x, o_y, o_pix_data, o_sof, cyc, p.x, p.y, p.d, p.sof, p.cyc);
            end
          end
        end else if (o_sof) begin
          checks++;
          errors++;
          $display("FAIL sof_alone: got sof=1 valid=0, required sof only with valid");
        end
        if (o_wr_en) begin
          checks++;
          if (q_wr.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: got addr=%0d, required no write", o_wr_addr);
          end else begin
            w = q_wr.pop_front();
            if (int'(o_wr_addr) != w.addr || int'(o_wr_data) != w.d || cyc != w.cyc) begin
              errors++;
              $display("FAIL wr: got addr=%0d d=%0d cyc=%0d, required addr=%0d d=%0d cyc=%0d",
                       o_wr_addr, o_wr_data, cyc, w.addr, w.d, w.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    int ha, hb;
    rst_n = 1'b0;
    i_vs = 1'b1; i_hs = 1'b1; i_de = 1'b0; i_data = 8'd0;
    v_act_n = int'($urandom_range(14, 20));
    v_tot = v_act_n + 6;
    vs_s = v_act_n + 2;
    ha = int'($urandom_range(18, 26));
    hb = int'($urandom_range(10, 16));
    m_sync = 0; m_track = 0; m_lock = 0;
    m_ht = 0; m_ha = 0; m_vt = 0; m_va = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_reset_outputs();
    end
    rst_n = 1'b1;
    repeat (4) send_frame(ha + 12, ha, v_act_n, -1);
    send_frame(ha + 12, ha, v_act_n - 1, -1);
    repeat (2) send_frame(ha + 12, ha, v_act_n, -1);
    repeat (3) send_frame(hb + 12, hb, v_act_n, -1);
    send_frame(ha + 12, ha, v_act_n, int'($urandom_range(2, v_act_n - 1)));
    repeat (3) send_frame(ha + 12, ha, v_act_n, -1);
    repeat (8) drive_cycle(1'b1, 1'b1, 1'b0, 8'd0);
    chk("pix_queue_drained", q_pix.size(), 0);
    chk("wr_queue_drained", q_wr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
